// File: rtl/can_pkg.sv
// can_pkg: constants shared by the CAN TX and RX bit-stream paths.
//   CAN_CRC_W     : CRC-15 width of classic CAN
//   CAN_CRC_POLY  : CRC-15 generator polynomial (x^15 implied)
//   CAN_STUFF_LEN : identical consecutive bits that force a stuff bit
//   can_crc_step  : advances the CRC register by one bus bit
package can_pkg;

  localparam int                  CAN_CRC_W     = 15;
  localparam logic [CAN_CRC_W-1:0] CAN_CRC_POLY = 15'h4599;
  localparam int                  CAN_STUFF_LEN = 5;

  function automatic logic [CAN_CRC_W-1:0] can_crc_step(input logic [CAN_CRC_W-1:0] crc,
                                                        input logic                 din);
    logic nxt;
    nxt = din ^ crc[CAN_CRC_W-1];
    return {crc[CAN_CRC_W-2:0], 1'b0} ^ (nxt ? CAN_CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/can_destuff.sv
// can_destuff: removes stuff bits from the sampled RX bit stream.
//   clk_can_i, rst_i : CAN core clock, asynchronous active-low reset
//   sample_i         : rx_bit_i is valid this cycle (bit sample point)
//   rx_bit_i         : sampled bus level (0 = dominant)
//   sof_i            : SOF bit; restarts the run counter and clears the error
//   stuff_en_i       : stuffing region active
//   data_o           : combinational: the current sample is a data bit
//   stuff_err_o      : registered, sticky stuff error until the next SOF
module can_destuff
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN
) (
  input  logic clk_can_i,
  input  logic rst_i,
  input  logic sample_i,
  input  logic rx_bit_i,
  input  logic sof_i,
  input  logic stuff_en_i,
  output logic data_o,
  output logic stuff_err_o
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);

  logic [RUN_W-1:0] run_cnt;
  logic             last_bit;
  logic             is_stuff;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    is_stuff = (run_cnt == RUN_W'(STUFF_LEN));
    data_o   = sample_i & (sof_i | (stuff_en_i & ~is_stuff));
  end

  always_ff @(posedge clk_can_i or negedge rst_i) begin
    if (!rst_i) begin
      run_cnt     <= '0;
      last_bit    <= 1'b1;
      stuff_err_o <= 1'b0;
    end else if (sample_i) begin
      if (sof_i) begin
        run_cnt     <= RUN_W'(1);
        last_bit    <= rx_bit_i;
        stuff_err_o <= 1'b0;
      end else if (!stuff_en_i) begin
        // Leaving the stuffing region forgets the run, so re-entry never expects a stuff bit first.
        run_cnt <= '0;
      end else if (is_stuff) begin
        // A stuff bit starts a new run; an equal-level "stuff bit" is an error but also restarts the run.
        run_cnt  <= RUN_W'(1);
        last_bit <= rx_bit_i;
        if (rx_bit_i == last_bit) stuff_err_o <= 1'b1;
      end else begin
        run_cnt  <= (rx_bit_i == last_bit) ? run_cnt + RUN_W'(1) : RUN_W'(1);
        last_bit <= rx_bit_i;
      end
    end
  end

endmodule

// File: rtl/can_rx_destuff_crc.sv
// can_rx_destuff_crc: RX destuffing plus CRC-15 computation and check.
//   clk_can_i, rst_i : CAN core clock, asynchronous active-low reset
//   sample_i, rx_bit_i, sof_i, stuff_en_i : sampled bit stream and framing
//   crc_phase_i      : destuffed bits belong to the received CRC sequence
//   check_i          : CRC delimiter sample, requests a verdict
//   bit_valid_o/bit_o: destuffed data bit strobe and value
//   stuff_err_o      : sticky stuff error
//   crc_ok_o/crc_err_o : one-cycle verdict pulses (mutually exclusive)
//   crc_calc_o       : running CRC over SOF..data
module can_rx_destuff_crc
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN,
  parameter int CRC_W     = CAN_CRC_W
) (
  input  logic             clk_can_i,
  input  logic             rst_i,
  input  logic             sample_i,
  input  logic             rx_bit_i,
  input  logic             sof_i,
  input  logic             stuff_en_i,
  input  logic             crc_phase_i,
  input  logic             check_i,
  output logic             bit_valid_o,
  output logic             bit_o,
  output logic             stuff_err_o,
  output logic             crc_ok_o,
  output logic             crc_err_o,
  output logic [CRC_W-1:0] crc_calc_o
);

  localparam int CNT_W = $clog2(CRC_W + 1);

  logic             data_take;
  logic [CRC_W-1:0] rx_crc;
  logic [CNT_W-1:0] crc_cnt;

  can_destuff #(.STUFF_LEN(STUFF_LEN)) u_destuff (
    .clk_can_i   (clk_can_i),
    .rst_i       (rst_i),
    .sample_i    (sample_i),
    .rx_bit_i    (rx_bit_i),
    .sof_i       (sof_i),
    .stuff_en_i  (stuff_en_i),
    .data_o      (data_take),
    .stuff_err_o (stuff_err_o)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_can_i or negedge rst_i) begin
    if (!rst_i) begin
      bit_valid_o <= 1'b0;
      bit_o       <= 1'b0;
      crc_ok_o    <= 1'b0;
      crc_err_o   <= 1'b0;
      crc_calc_o  <= '0;
      rx_crc      <= '0;
      crc_cnt     <= '0;
    end else begin
      bit_valid_o <= data_take;
      if (data_take) bit_o <= rx_bit_i;

      // Verdict uses the state accumulated before this edge; a stuff error always forces a fail.
      crc_ok_o  <= 1'b0;
      crc_err_o <= 1'b0;
      if (check_i) begin
        if (crc_cnt == CNT_W'(CRC_W) && rx_crc == crc_calc_o && !stuff_err_o) crc_ok_o  <= 1'b1;
        else                                                                 crc_err_o <= 1'b1;
      end

      if (sample_i && sof_i) begin
        // The SOF bit is the first CRC input, seeded from zero.
        crc_calc_o <= can_crc_step('0, rx_bit_i);
        rx_crc     <= '0;
        crc_cnt    <= '0;
      end else if (data_take) begin
        if (crc_phase_i) begin
          rx_crc <= {rx_crc[CRC_W-2:0], rx_bit_i};
          if (crc_cnt != CNT_W'(CRC_W)) crc_cnt <= crc_cnt + CNT_W'(1);
        end else begin
          crc_calc_o <= can_crc_step(crc_calc_o, rx_bit_i);
        end
      end
    end
  end

endmodule

// File: tb/tb_can_rx_destuff_crc.sv
// Self-checking bench for can_rx_destuff_crc: a queue-based reference model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_can_rx_destuff_crc;

  logic        clk_can_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        sample_i = 1'b0, rx_bit_i = 1'b0, sof_i = 1'b0;
  logic        stuff_en_i = 1'b0, crc_phase_i = 1'b0, check_i = 1'b0;
  logic        bit_valid_o, bit_o, stuff_err_o, crc_ok_o, crc_err_o;
  logic [14:0] crc_calc_o;

  can_rx_destuff_crc dut (
    .clk_can_i   (clk_can_i),
    .rst_i       (rst_i),
    .sample_i    (sample_i),
    .rx_bit_i    (rx_bit_i),
    .sof_i       (sof_i),
    .stuff_en_i  (stuff_en_i),
    .crc_phase_i (crc_phase_i),
    .check_i     (check_i),
    .bit_valid_o (bit_valid_o),
    .bit_o       (bit_o),
    .stuff_err_o (stuff_err_o),
    .crc_ok_o    (crc_ok_o),
    .crc_err_o   (crc_err_o),
    .crc_calc_o  (crc_calc_o)
  );

  always #5 clk_can_i = ~clk_can_i;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw bits since the last run restart, destuffed data bits,
  // received CRC bits, and the sticky error flag.
  bit          m_win[$];
  bit          m_data[$];
  bit          m_rx[$];
  bit          m_err;
  logic        e_valid, e_bit, e_ok, e_cerr;
  logic [14:0] e_crc;

  function automatic logic [14:0] crc_of(input bit q[$]);
    logic [14:0] c = '0;
    foreach (q[i]) begin
      if (q[i] ^ c[14]) c = {c[13:0], 1'b0} ^ 15'h4599;
      else              c = {c[13:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [14:0] rx_val(input bit q[$]);
    logic [14:0] v = '0;
    foreach (q[i]) v = {v[13:0], q[i]};
    return v;
  endfunction

  function automatic bit run_full(input bit q[$]);
    if (q.size() < 5) return 1'b0;
    for (int i = 1; i < q.size(); i++) if (q[i] != q[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_win.delete(); m_data.delete(); m_rx.delete(); m_err = 1'b0;
    e_valid = 0; e_bit = 0; e_ok = 0; e_cerr = 0; e_crc = '0;
  endtask

  task automatic model_step(input bit s, input bit b, input bit sof, input bit sen,
                            input bit cph, input bit chk);
    bit good;
    e_ok = 0; e_cerr = 0; e_valid = 0;
    if (chk) begin
      good   = (m_rx.size() >= 15) && (rx_val(m_rx) == crc_of(m_data)) && !m_err;
      e_ok   = good;
      e_cerr = !good;
    end
    if (s) begin
      if (sof) begin
        m_data.delete(); m_rx.delete(); m_err = 0;
        m_win.delete(); m_win.push_back(b);
        m_data.push_back(b);
        e_valid = 1; e_bit = b;
      end else if (!sen) begin
        m_win.delete();
      end else if (run_full(m_win)) begin
        if (b == m_win[$]) m_err = 1;
        m_win.delete(); m_win.push_back(b);
      end else begin
        m_win.push_back(b);
        if (m_win.size() > 5) void'(m_win.pop_front());
        e_valid = 1; e_bit = b;
        if (cph) m_rx.push_back(b);
        else     m_data.push_back(b);
      end
    end
    e_crc = crc_of(m_data);
  endtask

  // One clock: drive inputs, let the edge pass, advance the model.
  task automatic cyc(input bit s, input bit b, input bit sof, input bit sen,
                     input bit cph, input bit chk);
    sample_i = s; rx_bit_i = b; sof_i = sof; stuff_en_i = sen;
    crc_phase_i = cph; check_i = chk;
    @(posedge clk_can_i);
    #1;
    model_step(s, b, sof, sen, cph, chk);
    sample_i = 0; sof_i = 0; check_i = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk_can_i) begin
    if (cmp_en) begin
      check("bit_valid", 32'(bit_valid_o), 32'(e_valid));
      if (e_valid) check("bit", 32'(bit_o), 32'(e_bit));
      check("stuff_err", 32'(stuff_err_o), 32'(m_err));
      check("crc_ok", 32'(crc_ok_o), 32'(e_ok));
      check("crc_err", 32'(crc_err_o), 32'(e_cerr));
      check("crc_calc", 32'(crc_calc_o), 32'(e_crc));
      check("ok_err_exclusive", 32'(crc_ok_o & crc_err_o), 32'(0));
      if (bit_valid_o) vcount++;
    end
  end

  logic [14:0] pat;
  bit          q01[$];

  initial begin
    pat = 15'h4599;
    model_reset();
    q01.push_back(1'b0); q01.push_back(1'b1);
    check("model_crc_01", 32'(crc_of(q01)), 32'h4599);
    cmp_en = 1;
    repeat (3) @(posedge clk_can_i);
    #2 rst_i = 1;

    // Verdict with no SOF since reset.
    idle();
    cyc(1, 1, 0, 0, 0, 1);
    check("verdict_no_sof", 32'(crc_err_o), 32'(1));

    // Destuff pass: 0 x5, stuff 1, 0.
    vcount = 0;
    cyc(1, 0, 1, 1, 0, 0);
    repeat (4) cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    idle();
    check("destuff_valid_count", 32'(vcount), 32'(6));
    check("destuff_no_err", 32'(stuff_err_o), 32'(0));

    // Stuff error: six dominant bits from SOF.
    cyc(1, 0, 1, 1, 0, 0);
    repeat (4) cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    check("stuff_err_set", 32'(stuff_err_o), 32'(1));
    repeat (3) idle();
    check("stuff_err_sticky", 32'(stuff_err_o), 32'(1));
    cyc(1, 1, 0, 0, 0, 1);
    check("stuff_err_verdict", 32'(crc_err_o), 32'(1));

    // CRC pass.
    cyc(1, 0, 1, 1, 0, 0);
    check("sof_clears_err", 32'(stuff_err_o), 32'(0));
    cyc(1, 1, 0, 1, 0, 0);
    check("crc_after_01", 32'(crc_calc_o), 32'h4599);
    for (int i = 14; i >= 0; i--) cyc(1, pat[i], 0, 1, 1, 0);
    cyc(1, 1, 0, 0, 0, 1);
    check("pass_ok", 32'(crc_ok_o), 32'(1));
    check("pass_no_err", 32'(crc_err_o), 32'(0));
    idle();

    // CRC fail: last CRC bit flipped.
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    for (int i = 14; i >= 0; i--) cyc(1, (i == 0) ? ~pat[i] : pat[i], 0, 1, 1, 0);
    cyc(1, 1, 0, 0, 0, 1);
    check("flip_err", 32'(crc_err_o), 32'(1));
    check("flip_no_ok", 32'(crc_ok_o), 32'(0));

    // CRC fail: only 14 CRC bits.
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    for (int i = 14; i >= 1; i--) cyc(1, pat[i], 0, 1, 1, 0);
    cyc(1, 1, 0, 0, 0, 1);
    check("short_err", 32'(crc_err_o), 32'(1));

    // Stuff bit inside the CRC field, then stuff_en_i drop clearing the run.
    vcount = 0;
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    repeat (5) cyc(1, 1, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 1, 0);
    repeat (3) cyc(1, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    repeat (4) cyc(1, 0, 0, 1, 1, 0);
    idle();
    check("boundary_valid_count", 32'(vcount), 32'(14));
    check("boundary_no_err", 32'(stuff_err_o), 32'(0));
    cyc(1, 1, 0, 0, 0, 1);
    check("boundary_verdict", 32'(crc_err_o), 32'(1));

    // Asynchronous reset mid-frame.
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    #2 rst_i = 0;
    model_reset();
    #1;
    check("rst_crc_calc", 32'(crc_calc_o), 32'(0));
    check("rst_bit_valid", 32'(bit_valid_o), 32'(0));
    check("rst_outputs", 32'({bit_o, stuff_err_o, crc_ok_o, crc_err_o}), 32'(0));
    repeat (2) @(posedge clk_can_i);
    #2 rst_i = 1;
    cyc(1, 1, 0, 0, 0, 1);
    check("rst_verdict", 32'(crc_err_o), 32'(1));
    idle();

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
